// File: rtl/mem_bus_arbiter.sv
// Round-robin memory-bus arbiter with debug override, burst lock and I/O back-pressure.
// Decodes the granted master onto RAM or I/O and steers registered read data back.
module mem_bus_arbiter #(
    parameter int unsigned NUM_MASTERS    = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned RAM_ADDR_WIDTH = 17,
    parameter int unsigned PRIO_MASTER    = NUM_MASTERS - 1
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              prio_hold_in,
    input  logic [NUM_MASTERS-1:0]            m_req_in,
    input  logic [NUM_MASTERS-1:0]            m_lock_in,
    input  logic [NUM_MASTERS-1:0]            m_wr_in,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a_in,
    input  logic [NUM_MASTERS*8-1:0]          m_dout_in,
    output logic [NUM_MASTERS-1:0]            m_gnt_out,
    output logic [NUM_MASTERS-1:0]            m_rvalid_out,
    output logic [7:0]                        m_din_out,
    output logic                              ram_en_out,
    output logic                              ram_wr_out,
    output logic [RAM_ADDR_WIDTH-1:0]         ram_a_out,
    output logic [7:0]                        ram_d_out,
    input  logic [7:0]                        ram_q_in,
    output logic                              io_en_out,
    output logic                              io_wr_out,
    output logic [2:0]                        io_sel_out,
    output logic [7:0]                        io_d_out,
    input  logic [7:0]                        io_q_in,
    input  logic                              io_full_in
);

    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

    logic [ADDR_WIDTH-1:0]  addr  [NUM_MASTERS];
    logic [7:0]             wdata [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] is_io;
    logic [NUM_MASTERS-1:0] elig;

    logic [IDX_W-1:0] last_gnt_q;
    logic             lock_vld_q;
    logic [IDX_W-1:0] lock_idx_q;
    logic             q_rd_q;
    logic [IDX_W-1:0] q_idx_q;
    logic             q_io_q;

    logic             gnt_any;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] cand;
    logic             sel_io;
    logic             sel_ram;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_dec
        assign addr[i]  = m_a_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata[i] = m_dout_in[i*8 +: 8];
        assign is_io[i] = (addr[i][RAM_ADDR_WIDTH -: 2] == 2'b11);
        // An I/O write into a full buffer simply waits with its request held.
        assign elig[i]  = m_req_in[i] & ~(m_wr_in[i] & is_io[i] & io_full_in);
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (prio_hold_in) begin
            if (elig[PRIO_MASTER]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(PRIO_MASTER);
            end
        end else if (lock_vld_q && elig[lock_idx_q]) begin
            gnt_any = 1'b1;
            gnt_idx = lock_idx_q;
        end else begin
            // Walk from farthest to nearest so the nearest eligible master is the last write.
            for (int k = NUM_MASTERS; k >= 1; k--) begin
                cand = IDX_W'((int'(last_gnt_q) + k) % int'(NUM_MASTERS));
                if (elig[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        sel_io  = gnt_any & is_io[gnt_idx];
        sel_ram = gnt_any & ~is_io[gnt_idx];

        m_gnt_out = '0;
        if (gnt_any) begin
            m_gnt_out[gnt_idx] = 1'b1;
        end

        ram_en_out = sel_ram;
        ram_wr_out = sel_ram & m_wr_in[gnt_idx];
        ram_a_out  = sel_ram ? addr[gnt_idx][RAM_ADDR_WIDTH-1:0] : '0;
        ram_d_out  = sel_ram ? wdata[gnt_idx] : 8'h00;

        io_en_out  = sel_io;
        io_wr_out  = sel_io & m_wr_in[gnt_idx];
        io_sel_out = sel_io ? addr[gnt_idx][2:0] : 3'b000;
        io_d_out   = sel_io ? wdata[gnt_idx] : 8'h00;

        m_rvalid_out = '0;
        if (q_rd_q) begin
            m_rvalid_out[q_idx_q] = 1'b1;
        end
        m_din_out = q_io_q ? io_q_in : ram_q_in;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            last_gnt_q <= IDX_W'(NUM_MASTERS - 1);
            lock_vld_q <= 1'b0;
            lock_idx_q <= '0;
            q_rd_q     <= 1'b0;
            q_idx_q    <= '0;
            q_io_q     <= 1'b0;
        end else begin
            if (gnt_any) begin
                last_gnt_q <= gnt_idx;
            end
            // The override drops any burst in progress; the stalled master re-arbitrates.
            lock_vld_q <= gnt_any & m_lock_in[gnt_idx] & ~prio_hold_in;
            lock_idx_q <= gnt_idx;
            q_rd_q     <= gnt_any & ~m_wr_in[gnt_idx];
            q_idx_q    <= gnt_idx;
            q_io_q     <= sel_io;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, hand-written multi-cycle sequences
// and randomized traffic checked against a behavioural model.
module tb_mem_bus_arbiter;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           prio;
    logic           full;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N-1:0]   wr;
    logic [31:0]    a [N];
    logic [7:0]     d [N];
    logic [N*32-1:0] m_a;
    logic [N*8-1:0]  m_d;

    logic [N-1:0]   m_gnt;
    logic [N-1:0]   m_rvalid;
    logic [7:0]     m_din;
    logic           ram_en;
    logic           ram_wr;
    logic [16:0]    ram_a;
    logic [7:0]     ram_d;
    logic [7:0]     ram_q;
    logic           io_en;
    logic           io_wr;
    logic [2:0]     io_sel;
    logic [7:0]     io_d;
    logic [7:0]     io_q;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model state
    int        md_last;
    bit        md_lock_v;
    int        md_lock_i;
    bit        md_pend;
    int        md_pend_i;
    logic [7:0] md_pend_data;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            m_a[i*32 +: 32] = a[i];
            m_d[i*8 +: 8]   = d[i];
        end
    end

    mem_bus_arbiter #(
        .NUM_MASTERS    (N),
        .ADDR_WIDTH     (32),
        .RAM_ADDR_WIDTH (17),
        .PRIO_MASTER    (N - 1)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .prio_hold_in (prio),
        .m_req_in     (req),
        .m_lock_in    (lock),
        .m_wr_in      (wr),
        .m_a_in       (m_a),
        .m_dout_in    (m_d),
        .m_gnt_out    (m_gnt),
        .m_rvalid_out (m_rvalid),
        .m_din_out    (m_din),
        .ram_en_out   (ram_en),
        .ram_wr_out   (ram_wr),
        .ram_a_out    (ram_a),
        .ram_d_out    (ram_d),
        .ram_q_in     (ram_q),
        .io_en_out    (io_en),
        .io_wr_out    (io_wr),
        .io_sel_out   (io_sel),
        .io_d_out     (io_d),
        .io_q_in      (io_q),
        .io_full_in   (full)
    );

    function automatic logic [7:0] ram_byte(input logic [16:0] x);
        return x[7:0] ^ x[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] io_byte(input logic [2:0] s);
        return 8'hC0 | {5'b0, s};
    endfunction

    // Preloaded RAM and I/O register file, 1-cycle read latency; idle cycles return filler.
    always @(posedge clk) begin
        ram_q <= (ram_en && !ram_wr) ? ram_byte(ram_a) : 8'h3C;
        io_q  <= (io_en && !io_wr) ? io_byte(io_sel) : 8'h5A;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic bit is_io_addr(input logic [31:0] x);
        return x[17:16] == 2'b11;
    endfunction

    function automatic int model_grant();
        bit el [N];
        for (int i = 0; i < N; i++)
            el[i] = req[i] && !(wr[i] && is_io_addr(a[i]) && full);
        if (prio) return el[N-1] ? N - 1 : -1;
        if (md_lock_v && el[md_lock_i]) return md_lock_i;
        for (int k = 1; k <= N; k++)
            if (el[(md_last + k) % N]) return (md_last + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        md_last   = N - 1;
        md_lock_v = 0;
        md_lock_i = 0;
        md_pend   = 0;
        md_pend_i = 0;
        md_pend_data = 8'h00;
    endtask

    // Compare every output against the model, then advance the model one clock.
    task automatic model_check();
        int g;
        bit io, ren, ien;
        logic [N-1:0] eg, erv;
        g   = model_grant();
        io  = (g >= 0) && is_io_addr(a[g]);
        ren = (g >= 0) && !io;
        ien = (g >= 0) && io;
        eg  = '0;
        if (g >= 0) eg[g] = 1'b1;
        erv = '0;
        if (md_pend) erv[md_pend_i] = 1'b1;
        chk("m_gnt", m_gnt, eg);
        chk("m_rvalid", m_rvalid, erv);
        if (md_pend) chk("m_din", m_din, md_pend_data);
        chk("ram_en", ram_en, ren);
        chk("ram_wr", ram_wr, ren && wr[g]);
        chk("ram_a", ram_a, ren ? a[g][16:0] : 17'h0);
        chk("ram_d", ram_d, ren ? d[g] : 8'h0);
        chk("io_en", io_en, ien);
        chk("io_wr", io_wr, ien && wr[g]);
        chk("io_sel", io_sel, ien ? a[g][2:0] : 3'h0);
        chk("io_d", io_d, ien ? d[g] : 8'h0);
        if (g >= 0) md_last = g;
        md_lock_v = (g >= 0) && lock[g] && !prio;
        md_lock_i = (g >= 0) ? g : 0;
        md_pend   = (g >= 0) && !wr[g];
        md_pend_i = (g >= 0) ? g : 0;
        if (g >= 0) md_pend_data = io ? io_byte(a[g][2:0]) : ram_byte(a[g][16:0]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] w,
                          input logic p, input logic f, input logic [31:0] a0,
                          input logic [31:0] a1, input logic [7:0] d0, input logic [7:0] d1);
        req = r; lock = l; wr = w; prio = p; full = f;
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    endtask

    task automatic seq(input string nm, input logic [N-1:0] r, input logic [N-1:0] l,
                       input logic p, input logic [N-1:0] exp_gnt);
        set_in(r, l, 2'b00, p, 1'b0, 32'h10, 32'h20, 8'h00, 8'h00);
        @(negedge clk);
        chk(nm, m_gnt, exp_gnt);
        model_check();
        tick();
    endtask

    typedef struct {
        logic [1:0]  req, wr;
        logic        full;
        logic [31:0] a0, a1;
        logic [7:0]  d0;
        logic [1:0]  gnt, rvalid;
        logic        ram_en, io_en, io_wr;
        logic [16:0] ram_a;
        logic [2:0]  io_sel;
        logic [7:0]  io_d, din;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{2'b11, 2'b00, 0, 32'h10,    32'h20, 8'h00, 2'b01, 2'b00, 1, 0, 0, 17'h10, 3'd0, 8'h00, 8'h00};
        vecs[1] = '{2'b11, 2'b00, 0, 32'h10,    32'h20, 8'h00, 2'b10, 2'b01, 1, 0, 0, 17'h20, 3'd0, 8'h00, 8'hB5};
        vecs[2] = '{2'b11, 2'b00, 0, 32'h10,    32'h20, 8'h00, 2'b01, 2'b10, 1, 0, 0, 17'h10, 3'd0, 8'h00, 8'h85};
        vecs[3] = '{2'b11, 2'b00, 0, 32'h10,    32'h20, 8'h00, 2'b10, 2'b01, 1, 0, 0, 17'h20, 3'd0, 8'h00, 8'hB5};
        vecs[4] = '{2'b01, 2'b01, 1, 32'h30000, 32'h00, 8'h41, 2'b00, 2'b10, 0, 0, 0, 17'h00, 3'd0, 8'h00, 8'h85};
        vecs[5] = '{2'b01, 2'b01, 0, 32'h30000, 32'h00, 8'h41, 2'b01, 2'b00, 0, 1, 1, 17'h00, 3'd0, 8'h41, 8'h00};
        vecs[6] = '{2'b01, 2'b00, 0, 32'h30004, 32'h04, 8'h00, 2'b01, 2'b00, 0, 1, 0, 17'h00, 3'd4, 8'h00, 8'h00};
        vecs[7] = '{2'b10, 2'b00, 0, 32'h30004, 32'h04, 8'h00, 2'b10, 2'b01, 1, 0, 0, 17'h04, 3'd0, 8'h00, 8'hC4};
        vecs[8] = '{2'b00, 2'b00, 0, 32'h30004, 32'h04, 8'h00, 2'b00, 2'b10, 0, 0, 0, 17'h00, 3'd0, 8'h00, 8'hA1};
        vecs[9] = '{2'b00, 2'b00, 0, 32'h30004, 32'h04, 8'h00, 2'b00, 2'b00, 0, 0, 0, 17'h00, 3'd0, 8'h00, 8'h00};

        rst_n = 1'b0;
        set_in(2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 8'h0, 8'h0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", m_gnt, 2'b00);
        chk("reset_rvalid", m_rvalid, 2'b00);
        chk("reset_ram_en", ram_en, 1'b0);
        chk("reset_io_en", io_en, 1'b0);
        rst_n = 1'b1;
        tick();

        // Directed table: round-robin, back-pressure, return steering
        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].req, 2'b00, vecs[i].wr, 1'b0, vecs[i].full,
                   vecs[i].a0, vecs[i].a1, vecs[i].d0, 8'h00);
            @(negedge clk);
            chk($sformatf("vec%0d_gnt", i), m_gnt, vecs[i].gnt);
            chk($sformatf("vec%0d_rvalid", i), m_rvalid, vecs[i].rvalid);
            chk($sformatf("vec%0d_ram_en", i), ram_en, vecs[i].ram_en);
            chk($sformatf("vec%0d_io_en", i), io_en, vecs[i].io_en);
            chk($sformatf("vec%0d_io_wr", i), io_wr, vecs[i].io_wr);
            if (vecs[i].ram_en) chk($sformatf("vec%0d_ram_a", i), ram_a, vecs[i].ram_a);
            if (vecs[i].io_en) begin
                chk($sformatf("vec%0d_io_sel", i), io_sel, vecs[i].io_sel);
                chk($sformatf("vec%0d_io_d", i), io_d, vecs[i].io_d);
            end
            if (vecs[i].rvalid != 2'b00) chk($sformatf("vec%0d_din", i), m_din, vecs[i].din);
            model_check();
            tick();
        end

        // Lock burst: master 1 holds the bus for 4 cycles while master 0 waits
        seq("lock_pre", 2'b01, 2'b00, 1'b0, 2'b01);
        seq("lock_c1", 2'b11, 2'b10, 1'b0, 2'b10);
        seq("lock_c2", 2'b11, 2'b10, 1'b0, 2'b10);
        seq("lock_c3", 2'b11, 2'b10, 1'b0, 2'b10);
        seq("lock_c4", 2'b11, 2'b00, 1'b0, 2'b10);
        seq("lock_c5", 2'b11, 2'b00, 1'b0, 2'b01);

        // Debug override, including override arriving during a lock
        seq("prio_both", 2'b11, 2'b00, 1'b1, 2'b10);
        seq("prio_stall", 2'b01, 2'b00, 1'b1, 2'b00);
        seq("prio_lock0", 2'b01, 2'b01, 1'b0, 2'b01);
        seq("prio_vs_lock", 2'b11, 2'b01, 1'b1, 2'b10);
        seq("prio_release", 2'b11, 2'b00, 1'b0, 2'b01);

        // Reset with a read in flight
        set_in(2'b10, 2'b10, 2'b00, 1'b0, 1'b0, 32'h10, 32'h20, 8'h00, 8'h00);
        @(negedge clk);
        model_check();
        tick();
        chk("inflight_rvalid", m_rvalid, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("rst_rvalid", m_rvalid, 2'b00);
        model_reset();
        req = 2'b00;
        lock = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        seq("post_rst_first", 2'b11, 2'b00, 1'b0, 2'b01);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            set_in(2'($urandom), 2'($urandom), 2'($urandom), $urandom_range(0, 7) == 0,
                   1'($urandom), $urandom, $urandom, 8'($urandom), 8'($urandom));
            @(negedge clk);
            model_check();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Parametrised memory-bus arbiter and address decoder that lets `NUM_MASTERS` byte-wide masters (CPU fetch/data ports, host debug interface, future DMA) share one internal RAM and one I/O port window. It sits between the masters and the `ram`/`hci` I/O blocks in the top level. It adds the following over a fixed two-way mux:
- round-robin arbitration;
- a debug-override master;
- locked multi-byte bursts;
- I/O back-pressure;
- a registered read-return path that steers each byte back to the master that issued it.

## Interface
Parameters:
- `NUM_MASTERS`, 2, number of requesting masters (2..8)
- `ADDR_WIDTH`, 32, master address width
- `RAM_ADDR_WIDTH`, 17, RAM address width; 128 KiB
- `PRIO_MASTER`, NUM_MASTERS-1, index of the debug-override master

Ports:
- `clk_in`  in  1  system clock
- `rst_in`  in  1  reset; one clock; reset is asynchronous and active-low (0 = reset)
- `prio_hold_in`  in  1  debug override; only `PRIO_MASTER` may be granted while it is 1
- `m_req_in`  in  NUM_MASTERS  per-master access request
- `m_lock_in`  in  NUM_MASTERS  keep grant on the next cycle (burst)
- `m_wr_in`  in  NUM_MASTERS  1 = write, 0 = read
- `m_a_in`  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- `m_dout_in`  in  NUM_MASTERS*8  packed write data
- `m_gnt_out`  out  NUM_MASTERS  one-hot grant, same cycle as request
- `m_rvalid_out`  out  NUM_MASTERS  one-hot read-data-valid
- `m_din_out`  out  8  read data, broadcast to all masters; qualified by `m_rvalid_out`
- `ram_en_out`  out  1  RAM enable
- `ram_wr_out`  out  1  RAM write
- `ram_a_out`  out  RAM_ADDR_WIDTH  RAM address
- `ram_d_out`  out  8  RAM write data
- `ram_q_in`  in  8  RAM read data; 1-cycle latency
- `io_en_out`  out  1  I/O enable
- `io_wr_out`  out  1  I/O write
- `io_sel_out`  out  3  I/O register select, = a[2:0]
- `io_d_out`  out  8  I/O write data
- `io_q_in`  in  8  I/O read data; 1-cycle latency
- `io_full_in`  in  1  I/O output buffer full

## Operation

**Address decode**
- Decode uses bits a[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1].
- 2'b11 selects I/O; any other value selects RAM with `ram_a_out` = a[RAM_ADDR_WIDTH-1:0].

**Eligibility**
- Master i is eligible when `m_req_in[i]`=1.
- Exception: an I/O write while `io_full_in`=1 is not eligible. The master simply sees `m_gnt_out[i]`=0 and holds its request.

**Arbitration**, combinational, evaluated in priority order:
1. `prio_hold_in`=1: grant `PRIO_MASTER` if it is eligible, otherwise grant no one. This clears the lock.
2. Lock active and the locked master is eligible: grant the locked master.
3. Otherwise round-robin: the search starts at `last_gnt`+1 modulo NUM_MASTERS and grants the first eligible master.

**Sequential state**, updated on every posedge:
- `last_gnt` ← index of the granted master when any grant occurs; otherwise it holds.
- `lock_vld`/`lock_idx` ← (grant and `m_lock_in[g]`) / g. With no grant or no lock, `lock_vld` clears. If the locked master drops its request, the lock releases.
- Return pipeline: `q_rd` ← grant and not write; `q_idx` ← g; `q_io` ← decoded I/O.

**Outputs**
- The granted master's address, data and write are muxed onto the RAM or I/O port.
- The enable of the unselected port is 0.
- With no grant, all enables and writes are 0. Address and data outputs are then don't-care, driven 0.
- Read return: `m_rvalid_out` = `q_rd` ? onehot(`q_idx`) : 0.
- Read data: `m_din_out` = `q_io` ? `io_q_in` : `ram_q_in`. This is the registered select, so a region change on the next request cannot corrupt returning data.

## Timing
- Grant and RAM/I/O strobes are issued in the same cycle as the request (0 cycles).
- Read data and `m_rvalid_out` appear exactly 1 cycle after the granted cycle.
- Back-to-back reads from different masters are pipelined at full rate: 1 byte per cycle.
- Reset values: `last_gnt`=NUM_MASTERS-1 (master 0 wins first), `lock_vld`=0, `q_rd`=0, `q_idx`=0, `q_io`=0.
  - Hence after reset every output is 0: `m_gnt_out`=0 and `m_rvalid_out`=0 while no request is present.
- Reset asserted mid-burst or with a read in flight: the lock and the pending `m_rvalid_out` are discarded immediately (asynchronous).
- `prio_hold_in` rising during a lock: override wins in that same cycle. The locked master is stalled and must re-arbitrate after release.
- `io_full_in` toggles apply combinationally in the same cycle.
- Reads and RAM writes are never blocked by `io_full_in`.

## Test plan
- **Round-robin:** masters 0 and 1 both request RAM reads of 0x00010, 0x00020 for 4 cycles after reset → grants 0,1,0,1. `m_rvalid_out` 01,10,01,10 delayed 1 cycle. `m_din_out` matches preloaded RAM bytes.
- **Lock burst:** master 1 requests with lock for 4 cycles while master 0 requests → master 1 granted 4 consecutive cycles, then master 0 granted on cycle 5.
- **Debug override:** `prio_hold_in`=1 with both requesting → only master 1 (PRIO) granted. Master 0 stalls with `m_gnt_out`=00 on cycles where master 1 idles.
- **I/O back-pressure:** master 0 writes 0x41 to 0x30000 with `io_full_in`=1 → no grant, `io_en_out`=0. Release full → `io_en_out`=1, `io_sel_out`=0, `io_d_out`=0x41 in that same cycle.
- **Return steering:** master 0 reads I/O 0x30004 then master 1 reads RAM 0x00004 on consecutive cycles → the first return takes `io_q_in`, the second `ram_q_in`, with no cross-contamination.
- **Reset during burst:** assert `rst_in`=0 while a read is in flight → `m_rvalid_out`=0 immediately. After release, the first grant goes to master 0.
